// File: rtl/ay8913_pkg.sv
// Shared types and constants for the AY-3-891x bus writer: bus codes, FSM states, command word.
package ay8913_pkg;

    localparam logic [1:0] BUS_INACTIVE = 2'b00;
    localparam logic [1:0] BUS_READ     = 2'b01;
    localparam logic [1:0] BUS_WRITE    = 2'b10;
    localparam logic [1:0] BUS_LATCH    = 2'b11;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CMD_W  = ADDR_W + DATA_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_GAP_A = 3'd2,
        ST_DATA  = 3'd3,
        ST_GAP_D = 3'd4
    } state_t;

    // 12-bit command word {addr[3:0], data[7:0]}
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

endpackage

// File: rtl/ay8913_bus_writer_if.sv
// Command port and PSG bus pins of the AY-3-891x bus writer.
interface ay8913_bus_writer_if
    import ay8913_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              bdir;
    logic              bc1;
    logic [7:0]        da_out;
    logic              da_oe;
    logic              busy;
    logic [LVL_W-1:0]  fifo_level;

    modport master (
        output cmd_valid, cmd_addr, cmd_data,
        input  cmd_ready, bdir, bc1, da_out, da_oe, busy, fifo_level
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_data,
        output cmd_ready, bdir, bc1, da_out, da_oe, busy, fifo_level
    );

endinterface

// File: rtl/ay8913_cmd_fifo.sv
// Synchronous command FIFO; full/empty/level are registered, head_c is the current read word.
module ay8913_cmd_fifo
    import ay8913_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  cmd_t                       push_data,
    input  logic                       pop,
    output cmd_t                       head_c,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_n;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head_c  = mem[rd_ptr];

    always_comb begin
        level_n = level;
        if (do_push && !do_pop) begin
            level_n = level + LVL_W'(1);
        end else if (!do_push && do_pop) begin
            level_n = level - LVL_W'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level_n;
            full  <= (level_n == LVL_W'(DEPTH));
            empty <= (level_n == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ay8913_bus_writer.sv
// Write-only AY-3-891x bus initiator: buffers (register, value) commands and replays them
// as LATCH/WRITE bus phases, optionally skipping the latch when the register is unchanged.
module ay8913_bus_writer
    import ay8913_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned GAP_CYCLES  = 1,
    parameter int unsigned ADDR_CACHE  = 1
) (
    input  logic              clk,
    input  logic              rst,
    ay8913_bus_writer_if.slave bus
);
    localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [ADDR_W-1:0] cur_addr, cur_addr_n;
    logic [DATA_W-1:0] cur_data, cur_data_n;
    logic [ADDR_W-1:0] last_addr, last_addr_n;
    logic              cache_vld, cache_vld_n;
    logic [1:0]        code_q, code_n;
    logic [7:0]        da_q, da_n;
    logic              oe_q, oe_n;
    logic              busy_q, busy_n;
    logic              start;
    logic              pop;
    logic              hit_c;

    cmd_t              head_c;
    cmd_t              push_word;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LVL_W-1:0]  fifo_level;

    assign push_word.addr = bus.cmd_addr;
    assign push_word.data = bus.cmd_data;

    ay8913_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.cmd_valid),
        .push_data (push_word),
        .pop       (pop),
        .head_c    (head_c),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign hit_c = (ADDR_CACHE != 0) && cache_vld && (head_c.addr == last_addr);

    // Next state plus bus decode of the current state; the decode is registered,
    // so the pins show each state one cycle after the state register enters it.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        cur_addr_n  = cur_addr;
        cur_data_n  = cur_data;
        last_addr_n = last_addr;
        cache_vld_n = cache_vld;
        code_n      = BUS_INACTIVE;
        da_n        = da_q;
        oe_n        = 1'b1;
        busy_n      = (state != ST_IDLE) || !fifo_empty;
        start       = 1'b0;
        pop         = 1'b0;

        case (state)
            ST_IDLE: begin
                oe_n  = 1'b0;
                start = !fifo_empty;
            end
            ST_ADDR: begin
                code_n = BUS_LATCH;
                da_n   = {4'h0, cur_addr};
                if (cnt == '0) begin
                    last_addr_n = cur_addr;
                    cache_vld_n = 1'b1;
                    state_n     = ST_GAP_A;
                    cnt_n       = GAP_LD;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            ST_GAP_A: begin
                if (cnt == '0) begin
                    state_n = ST_DATA;
                    cnt_n   = HOLD_LD;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            ST_DATA: begin
                code_n = BUS_WRITE;
                da_n   = cur_data;
                if (cnt == '0) begin
                    state_n = ST_GAP_D;
                    cnt_n   = GAP_LD;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            ST_GAP_D: begin
                if (cnt == '0) begin
                    start   = !fifo_empty;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: begin
                oe_n    = 1'b0;
                state_n = ST_IDLE;
            end
        endcase

        // Pop the next command; overrides the IDLE fall-through for back-to-back replay
        if (start) begin
            pop        = 1'b1;
            cur_addr_n = head_c.addr;
            cur_data_n = head_c.data;
            state_n    = hit_c ? ST_DATA : ST_ADDR;
            cnt_n      = HOLD_LD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cur_addr  <= '0;
            cur_data  <= '0;
            last_addr <= '0;
            cache_vld <= 1'b0;
            code_q    <= BUS_INACTIVE;
            da_q      <= '0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cur_addr  <= cur_addr_n;
            cur_data  <= cur_data_n;
            last_addr <= last_addr_n;
            cache_vld <= cache_vld_n;
            code_q    <= code_n;
            da_q      <= da_n;
            oe_q      <= oe_n;
            busy_q    <= busy_n;
        end
    end

    assign bus.bdir       = code_q[1];
    assign bus.bc1        = code_q[0];
    assign bus.da_out     = da_q;
    assign bus.da_oe      = oe_q;
    assign bus.busy       = busy_q;
    assign bus.cmd_ready  = ~fifo_full;
    assign bus.fifo_level = fifo_level;

    // The PSG read code must never appear on the bus
    no_read_code: assert property (@(posedge clk) disable iff (rst) code_q != BUS_READ);

endmodule

// File: tb/tb_ay8913_bus_writer.sv
// Bench for ay8913_bus_writer: directed bus traces plus a randomized run checked cycle by
// cycle against a command-level timing model and a PSG register-file scoreboard.
module tb_ay8913_bus_writer;
    import ay8913_pkg::*;

    localparam int DEPTH = 4;
    localparam int HOLD  = 2;
    localparam int GAP   = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic nc_en = 1'b0;
    logic cap_en = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    ay8913_bus_writer_if #(.FIFO_DEPTH(DEPTH)) bw_if ();
    ay8913_bus_writer_if #(.FIFO_DEPTH(DEPTH)) nc_if ();

    assign nc_if.cmd_valid = nc_en & bw_if.cmd_valid;
    assign nc_if.cmd_addr  = bw_if.cmd_addr;
    assign nc_if.cmd_data  = bw_if.cmd_data;

    ay8913_bus_writer #(.FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .ADDR_CACHE(1))
        dut (.clk(clk), .rst(rst), .bus(bw_if));
    ay8913_bus_writer #(.FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .ADDR_CACHE(0))
        dut_nc (.clk(clk), .rst(rst), .bus(nc_if));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] pk(input logic oe, input logic [1:0] code, input logic [7:0] da);
        return {oe, code, oe ? da : 8'h00};
    endfunction

    // Reference model state: accepted-but-unpopped commands and the expected bus per clock edge
    int         edge_cnt = 0;
    cmd_t       mq[$];
    logic [1:0] exp_code[int];
    logic [7:0] exp_da[int];
    int         t_free = 0;
    logic       lv = 1'b0;
    logic [3:0] la = 4'h0;
    logic       exp_busy = 1'b0;
    logic [7:0] ref_regs[16];
    logic [7:0] psg_regs[16];
    logic [3:0] psg_latch = 4'h0;
    logic [10:0] cap_c[$];
    logic [10:0] cap_n[$];

    // A command popped at edge p occupies the bus after edges p+1 .. t_free
    task automatic schedule(input int p, input cmd_t c);
        int t;
        t = p + 1;
        if (!(lv && c.addr == la)) begin
            for (int i = 0; i < HOLD; i++) begin exp_code[t] = BUS_LATCH; exp_da[t] = {4'h0, c.addr}; t++; end
            for (int i = 0; i < GAP; i++)  begin exp_code[t] = BUS_INACTIVE; exp_da[t] = {4'h0, c.addr}; t++; end
        end
        for (int i = 0; i < HOLD; i++) begin exp_code[t] = BUS_WRITE; exp_da[t] = c.data; t++; end
        for (int i = 0; i < GAP; i++)  begin exp_code[t] = BUS_INACTIVE; exp_da[t] = c.data; t++; end
        la = c.addr;
        lv = 1'b1;
        t_free = t - 1;
    endtask

    initial begin : model
        int   lvl_pre;
        cmd_t c;
        forever begin
            @(posedge clk);
            edge_cnt++;
            if (rst) begin
                mq.delete();
                exp_code.delete();
                exp_da.delete();
                t_free = 0;
                lv = 1'b0;
                exp_busy = 1'b0;
            end else begin
                lvl_pre = mq.size();
                exp_busy = (edge_cnt - 1 < t_free) || (lvl_pre > 0);
                if (edge_cnt >= t_free && lvl_pre > 0) schedule(edge_cnt, mq.pop_front());
                if (bw_if.cmd_valid && lvl_pre < DEPTH) begin
                    c.addr = bw_if.cmd_addr;
                    c.data = bw_if.cmd_data;
                    mq.push_back(c);
                    ref_regs[c.addr] = c.data;
                end
            end
        end
    end

    initial begin : monitor
        logic [1:0] ec;
        logic [7:0] ed;
        logic       eo;
        forever begin
            @(negedge clk);
            eo = exp_code.exists(edge_cnt);
            ec = eo ? exp_code[edge_cnt] : BUS_INACTIVE;
            ed = eo ? exp_da[edge_cnt] : 8'h00;
            chk("bus_code", 32'({bw_if.bdir, bw_if.bc1}), 32'(ec));
            chk("da_oe", 32'(bw_if.da_oe), 32'(eo));
            if (eo) chk("da_out", 32'(bw_if.da_out), 32'(ed));
            chk("fifo_level", 32'(bw_if.fifo_level), 32'(mq.size()));
            chk("cmd_ready", 32'(bw_if.cmd_ready), 32'(mq.size() < DEPTH));
            chk("busy", 32'(bw_if.busy), 32'(exp_busy));
            if ({bw_if.bdir, bw_if.bc1} == BUS_LATCH) psg_latch = bw_if.da_out[3:0];
            if ({bw_if.bdir, bw_if.bc1} == BUS_WRITE) psg_regs[psg_latch] = bw_if.da_out;
            if (cap_en) begin
                cap_c.push_back(pk(bw_if.da_oe, {bw_if.bdir, bw_if.bc1}, bw_if.da_out));
                cap_n.push_back(pk(nc_if.da_oe, {nc_if.bdir, nc_if.bc1}, nc_if.da_out));
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin : main
        logic [10:0] exp_t[$];
        logic [3:0]  b_addr[6];
        logic [7:0]  b_data[6];
        logic        rdy, took, found, drained;
        logic [3:0]  last_a;
        int          k, cyc, maxlvl, acc;

        bw_if.cmd_valid = 1'b0;
        bw_if.cmd_addr  = 4'h0;
        bw_if.cmd_data  = 8'h00;

        // Reset values with valid low
        #1;
        chk("rst_code", 32'({bw_if.bdir, bw_if.bc1}), 32'(0));
        chk("rst_da_out", 32'(bw_if.da_out), 32'(0));
        chk("rst_da_oe", 32'(bw_if.da_oe), 32'(0));
        chk("rst_busy", 32'(bw_if.busy), 32'(0));
        chk("rst_level", 32'(bw_if.fifo_level), 32'(0));
        chk("rst_ready", 32'(bw_if.cmd_ready), 32'(1));
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();

        // Single write: reg 7 <= 8'h38
        bw_if.cmd_valid = 1'b1; bw_if.cmd_addr = 4'h7; bw_if.cmd_data = 8'h38;
        cap_c.delete(); cap_n.delete(); cap_en = 1'b1;
        step();
        bw_if.cmd_valid = 1'b0;
        repeat (8) step();
        cap_en = 1'b0;
        exp_t = '{pk(0,2'b00,8'h00), pk(0,2'b00,8'h00),
                  pk(1,2'b11,8'h07), pk(1,2'b11,8'h07), pk(1,2'b00,8'h07),
                  pk(1,2'b10,8'h38), pk(1,2'b10,8'h38), pk(1,2'b00,8'h38),
                  pk(0,2'b00,8'h00)};
        chk("t2_len", 32'(cap_c.size()), 32'(exp_t.size()));
        for (int i = 0; i < exp_t.size(); i++) chk($sformatf("t2_trace%0d", i), 32'(cap_c[i]), 32'(exp_t[i]));
        chk("t2_busy", 32'(bw_if.busy), 32'(0));

        // Two writes to reg 8, with and without the address cache
        nc_en = 1'b1;
        bw_if.cmd_valid = 1'b1; bw_if.cmd_addr = 4'h8; bw_if.cmd_data = 8'h0F;
        cap_c.delete(); cap_n.delete(); cap_en = 1'b1;
        step();
        bw_if.cmd_data = 8'h0A;
        step();
        bw_if.cmd_valid = 1'b0;
        repeat (13) step();
        cap_en = 1'b0;
        nc_en = 1'b0;
        exp_t = '{pk(0,2'b00,8'h00), pk(0,2'b00,8'h00),
                  pk(1,2'b11,8'h08), pk(1,2'b11,8'h08), pk(1,2'b00,8'h08),
                  pk(1,2'b10,8'h0F), pk(1,2'b10,8'h0F), pk(1,2'b00,8'h0F),
                  pk(1,2'b10,8'h0A), pk(1,2'b10,8'h0A), pk(1,2'b00,8'h0A),
                  pk(0,2'b00,8'h00), pk(0,2'b00,8'h00), pk(0,2'b00,8'h00), pk(0,2'b00,8'h00)};
        for (int i = 0; i < exp_t.size(); i++) chk($sformatf("t3_cache%0d", i), 32'(cap_c[i]), 32'(exp_t[i]));
        exp_t = '{pk(0,2'b00,8'h00), pk(0,2'b00,8'h00),
                  pk(1,2'b11,8'h08), pk(1,2'b11,8'h08), pk(1,2'b00,8'h08),
                  pk(1,2'b10,8'h0F), pk(1,2'b10,8'h0F), pk(1,2'b00,8'h0F),
                  pk(1,2'b11,8'h08), pk(1,2'b11,8'h08), pk(1,2'b00,8'h08),
                  pk(1,2'b10,8'h0A), pk(1,2'b10,8'h0A), pk(1,2'b00,8'h0A),
                  pk(0,2'b00,8'h00)};
        for (int i = 0; i < exp_t.size(); i++) chk($sformatf("t3_nocache%0d", i), 32'(cap_n[i]), 32'(exp_t[i]));

        // Burst of 6 commands into a 4-deep FIFO
        for (int i = 0; i < 6; i++) begin
            b_addr[i] = 4'(i);
            b_data[i] = 8'($urandom);
        end
        k = 0; cyc = 0; maxlvl = 0;
        while (k < 6 && cyc < 100) begin
            step();
            if (int'(bw_if.fifo_level) > maxlvl) maxlvl = int'(bw_if.fifo_level);
            bw_if.cmd_valid = 1'b1;
            bw_if.cmd_addr  = b_addr[k];
            bw_if.cmd_data  = b_data[k];
            rdy = bw_if.cmd_ready;
            @(posedge clk);
            if (rdy) k++;
            cyc++;
        end
        step();
        bw_if.cmd_valid = 1'b0;
        chk("t4_accepted", 32'(k), 32'(6));
        chk("t4_maxlvl", 32'(maxlvl), 32'(DEPTH));
        drained = 1'b0;
        for (int i = 0; i < 100 && !drained; i++) begin
            step();
            drained = !bw_if.busy;
        end
        chk("t4_drain", 32'(drained), 32'(1));
        for (int i = 0; i < 6; i++) chk($sformatf("t4_reg%0d", i), 32'(psg_regs[b_addr[i]]), 32'(b_data[i]));

        // Reset in the middle of a data phase with commands still queued
        for (int i = 0; i < 3; i++) begin
            bw_if.cmd_valid = 1'b1; bw_if.cmd_addr = 4'(i + 1); bw_if.cmd_data = 8'(8'h50 + i);
            step();
        end
        bw_if.cmd_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if ({bw_if.bdir, bw_if.bc1} == BUS_WRITE) found = 1'b1;
            else step();
        end
        chk("t1_saw_write", 32'(found), 32'(1));
        rst = 1'b1;
        #1;
        chk("t1_mid_code", 32'({bw_if.bdir, bw_if.bc1}), 32'(0));
        chk("t1_mid_oe", 32'(bw_if.da_oe), 32'(0));
        chk("t1_mid_level", 32'(bw_if.fifo_level), 32'(0));
        chk("t1_mid_busy", 32'(bw_if.busy), 32'(0));
        chk("t1_mid_ready", 32'(bw_if.cmd_ready), 32'(1));
        step();
        rst = 1'b0;
        step();

        // Random commands scored against the PSG register file
        for (int r = 0; r < 16; r++) begin ref_regs[r] = 8'h00; psg_regs[r] = 8'h00; end
        acc = 0; cyc = 0; took = 1'b1; last_a = 4'h0;
        while (acc < 200 && cyc < 5000) begin
            step();
            if (took || !bw_if.cmd_valid) begin
                bw_if.cmd_valid = ($urandom_range(0, 3) != 0);
                bw_if.cmd_addr  = ($urandom_range(0, 2) == 0) ? last_a : 4'($urandom_range(0, 15));
                bw_if.cmd_data  = 8'($urandom);
                last_a = bw_if.cmd_addr;
            end
            rdy = bw_if.cmd_ready;
            @(posedge clk);
            took = bw_if.cmd_valid && rdy;
            if (took) acc++;
            cyc++;
        end
        step();
        bw_if.cmd_valid = 1'b0;
        chk("t6_count", 32'(acc), 32'(200));
        drained = 1'b0;
        for (int i = 0; i < 2000 && !drained; i++) begin
            step();
            drained = !bw_if.busy && (bw_if.fifo_level == '0);
        end
        chk("t6_drain", 32'(drained), 32'(1));
        for (int r = 0; r < 16; r++) chk($sformatf("t6_reg%0d", r), 32'(psg_regs[r]), 32'(ref_regs[r]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
